uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver for the bbcpu UART link; the receive-side counterpart of the CPU's uart_tx_line output.
- Frame format: line idles high, one start bit (low), WIDTH data bits LSB first, one stop bit (high).
- Oversamples the asynchronous line on the system clock, checks framing and holds one received byte.
- Presents the byte to the CPU or an I/O port through a valid/ready handshake.

Parameters:
- WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 2, system clocks per serial bit. Minimum 2; even values only. Default matches the TX bit rate (uart_clk = clk/2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx_line  input  1  asynchronous serial line; idle high.
- rx_data  output  WIDTH  holding register with the last accepted byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte; transfer occurs on a rising edge with rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - State → IDLE; all counters → 0.
  - Both synchronizer flops → 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame; no partial byte is ever presented.
- Synchronizer: two flops on uart_rx_line. The FSM sees only the second flop (s2).
- Definitions: H = CLKS_PER_BIT/2. Edge E0 is the first rising edge at which flop 1 captures 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: s2==0 → START with cnt=0. With default timing this transition happens at E2.
  - START:
    - cnt increments each edge.
    - At the edge where cnt==H-1, s2 is tested.
    - s2==1 means a false start → IDLE, nothing reported.
    - s2==0 → DATA with cnt=0 and bitcnt=0.
  - DATA:
    - cnt increments each edge.
    - At cnt==CLKS_PER_BIT-1: shift s2 into shift register bit bitcnt (LSB first), cnt=0, bitcnt++.
    - After bit WIDTH-1 is captured → STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample s2.
    - s2==1 → accept the frame (see holding register), then → IDLE.
    - s2==0 → frame_err=1 for exactly one cycle; byte discarded; → WAIT_IDLE.
  - WAIT_IDLE: stay until s2==1, then → IDLE. This handles a break or held-low line without spurious frames.
- Timing:
  - Bit k (k=0..WIDTH-1) is sampled at edge E(2+H+(k+1)*CLKS_PER_BIT).
  - The stop bit is sampled at E(2+H+(WIDTH+1)*CLKS_PER_BIT).
  - rx_valid is visible after that edge: E21 for defaults.
  - Each sample point is the bit centre, net of the 2-cycle synchronizer delay.
- Holding register and handshake:
  - rx_valid stays high and rx_data stays stable until rx_valid && rx_ready at an edge. rx_valid then clears on that edge unless a new frame is accepted on the same edge.
  - Frame accepted with rx_valid==0: rx_data ← shift register, rx_valid ← 1.
  - Frame accepted with rx_valid==1 and rx_ready==1 on the same edge: old byte consumed, new byte loaded, rx_valid stays 1, overrun unchanged.
  - Frame accepted with rx_valid==1 and rx_ready==0: new byte dropped, rx_data unchanged, overrun ← 1.
  - overrun clears on the next handshake edge (rx_valid && rx_ready). Set wins if set and clear coincide.
- Back-to-back frames:
  - A new start bit may follow the stop bit immediately.
  - IDLE is re-entered H cycles before the stop bit ends, so the next falling edge is caught.
- busy: 0 in IDLE, 1 in every other state, including WAIT_IDLE.
- Widths: cnt is $clog2(CLKS_PER_BIT) bits; bitcnt is $clog2(WIDTH)+1 bits. Counters never wrap within a frame.

Test Plan:
- Defaults, rx_ready=1, send frame 0x59 (line changes every 2 clocks) → rx_valid high after E21 with rx_data=0x59; cleared on the next edge; frame_err=0, overrun=0.
- Back-to-back frames with no idle gap, carrying Fibonacci bytes 1,1,2,3,5,8,13,21,34,55,89,144, rx_ready=1 → twelve handshakes in order with exactly those values; no frame_err, no overrun.
- Low glitch of 1 clock on an idle line → busy pulses, FSM returns to IDLE at the start check, rx_valid never asserts.
- Frame 0xA5 with stop bit driven low, line held low 10 more bit times then released high → one frame_err pulse; rx_valid stays 0; busy holds until the line is high; next frame 0x3C received correctly.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x11, rx_valid=1, overrun=1 after the second stop bit; raise rx_ready for one cycle → handshake of 0x11, rx_valid=0, overrun=0.
- Assert rst for one cycle at data bit 4 of frame 0x77 → all outputs 0 immediately (asynchronous); the remainder of the frame produces no valid; the following frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_if : received-byte handshake and status bundle for uart_rx         |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx  : oversampling UART receiver with framing check, one-byte holding |
// |            register and valid/ready output handshake                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic uart_rx_line,
    uart_rx_if.master rx
);

    localparam int c_cnt_w  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bcnt_w = $clog2(WIDTH) + 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one = c_bcnt_w'(1);
    localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bcnt_w-1:0]  r_bitcnt;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic                 w_accept;
    logic                 w_handshake;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_line;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_half_last) begin
                        if (r_sync2) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_cnt    <= '0;
                            r_bitcnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        // Right shift lands the first (LSB) bit at position 0 after WIDTH samples.
                        r_shift  <= {r_sync2, r_shift[WIDTH-1:1]};
                        r_cnt    <= '0;
                        r_bitcnt <= r_bitcnt + c_bcnt_one;
                        if (r_bitcnt == c_last_bit) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_WAIT_IDLE;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_accept    = (r_state == S_STOP) && (r_cnt == c_bit_last) && r_sync2;
    assign w_handshake = r_valid && rx.rx_ready;

    // Holding register: a simultaneous consume makes room for the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept && (!r_valid || rx.rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end

            if (w_accept && r_valid && !rx.rx_ready) begin
                r_overrun <= 1'b1;
            end else if (w_handshake && !w_accept) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = r_data;
    assign rx.rx_valid  = r_valid;
    assign rx.frame_err = r_frame_err;
    assign rx.overrun   = r_overrun;
    assign rx.busy      = r_busy;

endmodule
`default_nettype wire
